// File: rtl/counter_sched.sv
// -----------------------------------------------------------------------------
// counter_sched
//
// Shared-counter scheduler. Two requesters compete for a single up-counter.
// The winner's terminal count is latched at grant, the counter runs from 0 up
// to that value, a one-cycle done pulse goes back to the owner, and the block
// spends one cycle in DONE before it returns to IDLE. When both requesters ask
// at once, a round-robin pointer gives the grant to the one not served last.
//
// Optional feature (macro COUNTER_SCHED_ABORT_EN):
//   When defined, an owner that drops its request during COUNT aborts the run.
//   The block returns to IDLE on the next edge with no done pulse, and
//   priority still passes to the other requester. When undefined, the request
//   is ignored after grant and every run completes with a done pulse.
//
// Parameters:
//   WIDTH  counter and length width in bits (maximum length 2^WIDTH-1)
//
// Ports:
//   clk    rising-edge clock
//   res    asynchronous reset, active-low; clears all state immediately
//   req0   requester 0 request (level, held until done0 or abort)
//   len0   requester 0 terminal count, sampled only at grant
//   req1   requester 1 request
//   len1   requester 1 terminal count, sampled only at grant
//   gnt0   requester 0 owns the counter
//   gnt1   requester 1 owns the counter
//   done0  one-cycle completion pulse to requester 0
//   done1  one-cycle completion pulse to requester 1
//   busy   high in COUNT and DONE
//   cnt    current counter value
// -----------------------------------------------------------------------------
module counter_sched #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             res,
   input  logic             req0,
   input  logic [WIDTH-1:0] len0,
   input  logic             req1,
   input  logic [WIDTH-1:0] len1,
   output logic             gnt0,
   output logic             gnt1,
   output logic             done0,
   output logic             done1,
   output logic             busy,
   output logic [WIDTH-1:0] cnt
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      COUNT = 2'd1,
      DONE  = 2'd2
   } state_t;

   // Registered state.
   state_t           state_q;
   logic             owner_q;   // 0: requester 0 owns the counter, 1: requester 1
   logic [WIDTH-1:0] len_q;     // terminal count latched at grant
   logic             ptr_q;     // requester that wins a tie in IDLE

   // Next-state values.
   state_t           state_d;
   logic             owner_d;
   logic [WIDTH-1:0] len_d;
   logic             ptr_d;
   logic             gnt0_d;
   logic             gnt1_d;
   logic             done0_d;
   logic             done1_d;
   logic             busy_d;
   logic [WIDTH-1:0] cnt_d;

   // Winner of arbitration in IDLE: on a tie the pointer decides, otherwise
   // whichever requester is asking (req1 alone selects 1, req0 alone selects 0).
   logic pick;
   assign pick = (req0 && req1) ? ptr_q : req1;

`ifdef COUNTER_SCHED_ABORT_EN
   // Request level of the current owner, watched for an abort during COUNT.
   logic own_req;
   assign own_req = owner_q ? req1 : req0;
`endif

   // NOTE: every signal assigned in this block gets a default first, so no
   // path leaves a value unassigned and no latch is inferred.
   always_comb begin
      state_d = state_q;
      owner_d = owner_q;
      len_d   = len_q;
      ptr_d   = ptr_q;
      gnt0_d  = gnt0;
      gnt1_d  = gnt1;
      done0_d = 1'b0;
      done1_d = 1'b0;
      busy_d  = busy;
      cnt_d   = cnt;

      unique case (state_q)
         IDLE: begin
            gnt0_d = 1'b0;
            gnt1_d = 1'b0;
            busy_d = 1'b0;
            cnt_d  = '0;
            if (req0 || req1) begin
               owner_d = pick;
               len_d   = pick ? len1 : len0;
               gnt0_d  = !pick;
               gnt1_d  = pick;
               busy_d  = 1'b1;
               state_d = COUNT;
            end
         end

         COUNT: begin
`ifdef COUNTER_SCHED_ABORT_EN
            if (!own_req) begin
               // Abort: straight back to IDLE, no done pulse, priority moves on.
               state_d = IDLE;
               gnt0_d  = 1'b0;
               gnt1_d  = 1'b0;
               busy_d  = 1'b0;
               cnt_d   = '0;
               ptr_d   = !owner_q;
            end else
`endif
            if (cnt == len_q) begin
               // Terminal count reached: cnt holds, grant stays, done pulses.
               state_d = DONE;
               done0_d = !owner_q;
               done1_d = owner_q;
               ptr_d   = !owner_q;
            end else begin
               // cnt < len_q here, so the increment can never wrap.
               cnt_d = cnt + 1'b1;
            end
         end

         DONE: begin
            state_d = IDLE;
            gnt0_d  = 1'b0;
            gnt1_d  = 1'b0;
            busy_d  = 1'b0;
            cnt_d   = '0;
         end

         default: begin
            state_d = IDLE;
            gnt0_d  = 1'b0;
            gnt1_d  = 1'b0;
            busy_d  = 1'b0;
            cnt_d   = '0;
         end
      endcase
   end

   // NOTE: sequential state is updated with non-blocking assignments so every
   // register samples the values from before the edge, whatever the order.
   always_ff @(posedge clk or negedge res) begin
      if (!res) begin
         state_q <= IDLE;
         owner_q <= 1'b0;
         len_q   <= '0;
         ptr_q   <= 1'b0;
         gnt0    <= 1'b0;
         gnt1    <= 1'b0;
         done0   <= 1'b0;
         done1   <= 1'b0;
         busy    <= 1'b0;
         cnt     <= '0;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         len_q   <= len_d;
         ptr_q   <= ptr_d;
         gnt0    <= gnt0_d;
         gnt1    <= gnt1_d;
         done0   <= done0_d;
         done1   <= done1_d;
         busy    <= busy_d;
         cnt     <= cnt_d;
      end
   end

   // Structural invariants of the scheduler.
   a_gnt_onehot : assert property (@(posedge clk) disable iff (!res)
      !(gnt0 && gnt1));
   a_done_onehot : assert property (@(posedge clk) disable iff (!res)
      !(done0 && done1));
   a_cnt_bound : assert property (@(posedge clk) disable iff (!res)
      (state_q != IDLE) |-> (cnt <= len_q));

endmodule

// File: tb/tb_counter_sched.sv
// -----------------------------------------------------------------------------
// tb_counter_sched
//
// Self-checking bench for counter_sched (WIDTH = 4). A transaction-level
// reference model tracks at most one active run as (owner, latched length,
// age in cycles since grant) and derives every expected output arithmetically
// from that. Directed sequences cover reset, a single run, contention and
// alternation, length 0 and 15, abort or its absence, and reset mid-count;
// a randomized phase then drives both requesters with $urandom.
// Compile with +define+COUNTER_SCHED_ABORT_EN to match an abort-enabled build.
// -----------------------------------------------------------------------------
module tb_counter_sched;

   localparam int W = 4;

   logic         clk = 1'b0;
   logic         res;
   logic         req0, req1;
   logic [W-1:0] len0, len1;
   logic         gnt0, gnt1, done0, done1, busy;
   logic [W-1:0] cnt;

   int total = 0;
   int bad   = 0;

   counter_sched #(.WIDTH(W)) dut (
      .clk  (clk),
      .res  (res),
      .req0 (req0),
      .len0 (len0),
      .req1 (req1),
      .len1 (len1),
      .gnt0 (gnt0),
      .gnt1 (gnt1),
      .done0(done0),
      .done1(done1),
      .busy (busy),
      .cnt  (cnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input int obs, input int exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   // One run at a time: grant at age 0, counting while age <= len,
   // done at age len+1, then back to idle on the following edge.
   bit m_active;
   int m_who;
   int m_len;
   int m_age;
   int m_last;   // requester served last; 1 after reset so requester 0 wins a tie

   int e_gnt0, e_gnt1, e_done0, e_done1, e_busy, e_cnt;

   function automatic void model_reset();
      m_active = 0;
      m_who    = 0;
      m_len    = 0;
      m_age    = 0;
      m_last   = 1;
   endfunction

   function automatic void model_outputs();
      e_busy  = m_active ? 1 : 0;
      e_gnt0  = (m_active && m_who == 0) ? 1 : 0;
      e_gnt1  = (m_active && m_who == 1) ? 1 : 0;
      e_cnt   = !m_active ? 0 : (m_age > m_len ? m_len : m_age);
      e_done0 = (m_active && m_who == 0 && m_age == m_len + 1) ? 1 : 0;
      e_done1 = (m_active && m_who == 1 && m_age == m_len + 1) ? 1 : 0;
   endfunction

   // Advance the model by one rising edge, using the inputs seen at that edge.
   function automatic void model_step();
      int who;
      if (!m_active) begin
         if (req0 && req1) who = (m_last == 0) ? 1 : 0;
         else if (req0)    who = 0;
         else if (req1)    who = 1;
         else              who = -1;
         if (who >= 0) begin
            m_active = 1;
            m_who    = who;
            m_len    = (who == 1) ? int'(len1) : int'(len0);
            m_age    = 0;
         end
      end else if (m_age == m_len + 1) begin
         m_active = 0;
      end else begin
`ifdef COUNTER_SCHED_ABORT_EN
         if (!((m_who == 1) ? req1 : req0)) begin
            m_active = 0;
            m_last   = m_who;
         end else
`endif
         begin
            m_age++;
            if (m_age == m_len + 1) m_last = m_who;
         end
      end
      model_outputs();
   endfunction

   // ---------------- stimulus helpers ----------------
   task automatic compare_all();
      check("gnt0",  int'(gnt0),  e_gnt0);
      check("gnt1",  int'(gnt1),  e_gnt1);
      check("done0", int'(done0), e_done0);
      check("done1", int'(done1), e_done1);
      check("busy",  int'(busy),  e_busy);
      check("cnt",   int'(cnt),   e_cnt);
   endtask

   // One clock: model follows the edge, outputs compared 1 time unit later,
   // and a requester that has just seen its done pulse releases its request.
   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
      compare_all();
      if (e_done0 == 1) req0 = 1'b0;
      if (e_done1 == 1) req1 = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      res  = 1'b0;
      req0 = 1'b0;
      req1 = 1'b0;
      model_reset();
      model_outputs();
      @(negedge clk);
      res = 1'b1;
   endtask

   function automatic logic [W-1:0] rand_len();
      case ($urandom_range(3))
         0:       return '0;
         1:       return '1;
         default: return W'($urandom_range(15));
      endcase
   endfunction

   int last_who;

   initial begin
      res  = 1'b0;
      req0 = 1'b1;
      len0 = 4'd5;
      req1 = 1'b0;
      len1 = 4'd0;
      model_reset();
      model_outputs();

      // ---- reset held with req0 high: everything stays at 0 ----
      repeat (3) begin
         @(posedge clk);
         #1;
         check("rst_gnt0", int'(gnt0), 0);
         check("rst_busy", int'(busy), 0);
         check("rst_cnt",  int'(cnt),  0);
      end
      @(negedge clk);
      res = 1'b1;

      // ---- single requester, len0 = 5: grant on the first edge ----
      tick();
      check("first_gnt0", int'(gnt0), 1);
      for (int k = 1; k <= 5; k++) begin
         tick();
         check("seq_cnt", int'(cnt), k);
      end
      tick();
      check("len5_done0", int'(done0), 1);
      check("len5_cnt",   int'(cnt),   5);
      tick();
      check("len5_gnt0_off", int'(gnt0), 0);
      check("len5_busy_off", int'(busy), 0);

      // ---- contention after reset: 0 first, one idle cycle, then 1 ----
      do_reset();
      req0 = 1'b1; len0 = 4'd2;
      req1 = 1'b1; len1 = 4'd2;
      tick();
      check("cont_first_gnt0", int'(gnt0), 1);
      repeat (3) tick();          // cnt 1, cnt 2, done0
      check("cont_done0", int'(done0), 1);
      tick();                     // the single IDLE cycle
      check("cont_idle_busy", int'(busy), 0);
      tick();
      check("cont_then_gnt1", int'(gnt1), 1);

      // ---- both held: grants alternate ----
      last_who = 1;
      for (int c = 0; c < 60; c++) begin
         logic g0_prev, g1_prev;
         g0_prev = gnt0;
         g1_prev = gnt1;
         if (!req0 && e_done0 == 0) req0 = 1'b1;
         if (!req1 && e_done1 == 0) req1 = 1'b1;
         tick();
         if ((gnt0 && !g0_prev) || (gnt1 && !g1_prev)) begin
            check("alt_order", gnt1 ? 1 : 0, (last_who == 0) ? 1 : 0);
            last_who = gnt1 ? 1 : 0;
         end
      end

      // ---- len1 = 0: done one edge after grant ----
      do_reset();
      req1 = 1'b1; len1 = 4'd0;
      tick();
      check("len0_gnt1", int'(gnt1), 1);
      tick();
      check("len0_done1", int'(done1), 1);
      tick();

      // ---- len1 = 15: counts to all-ones, done after 16 edges ----
      do_reset();
      req1 = 1'b1; len1 = 4'd15;
      tick();
      len1 = 4'd3;                // ignored after grant
      repeat (15) tick();
      check("len15_cnt",       int'(cnt),   15);
      check("len15_not_done",  int'(done1), 0);
      tick();
      check("len15_done1",     int'(done1), 1);
      check("len15_hold_cnt",  int'(cnt),   15);
      tick();

      // ---- drop req0 at cnt = 3 with len0 = 9 ----
      do_reset();
      req0 = 1'b1; len0 = 4'd9;
      tick();
      repeat (3) tick();
      check("abort_at3", int'(cnt), 3);
      req0 = 1'b0;
      tick();
`ifdef COUNTER_SCHED_ABORT_EN
      check("abort_gnt0", int'(gnt0),  0);
      check("abort_done", int'(done0), 0);
      check("abort_cnt",  int'(cnt),   0);
`else
      check("noabort_cnt4", int'(cnt), 4);
      repeat (5) tick();
      check("noabort_cnt9", int'(cnt), 9);
      tick();
      check("noabort_done0", int'(done0), 1);
      tick();
`endif

      // ---- reset mid-count ----
      do_reset();
      req0 = 1'b1; len0 = 4'd9;
      tick();
      repeat (4) tick();
      check("mid_cnt4", int'(cnt), 4);
      #2;
      res  = 1'b0;
      req0 = 1'b0;
      #1;
      check("mid_gnt0",  int'(gnt0),  0);
      check("mid_busy",  int'(busy),  0);
      check("mid_cnt",   int'(cnt),   0);
      check("mid_done0", int'(done0), 0);
      model_reset();
      model_outputs();
      @(negedge clk);
      @(negedge clk);
      res = 1'b1;
      repeat (3) tick();
      check("mid_idle_cnt", int'(cnt), 0);

      // ---- randomized traffic ----
      for (int c = 0; c < 2000; c++) begin
         if (req0 && $urandom_range(3) == 0) len0 = W'($urandom_range(15));
         if (req1 && $urandom_range(3) == 0) len1 = W'($urandom_range(15));
         if (!req0 && e_done0 == 0 && $urandom_range(2) == 0) begin
            req0 = 1'b1;
            len0 = rand_len();
         end
         if (!req1 && e_done1 == 0 && $urandom_range(2) == 0) begin
            req1 = 1'b1;
            len1 = rand_len();
         end
`ifdef COUNTER_SCHED_ABORT_EN
         if (m_active && m_age <= m_len && $urandom_range(15) == 0) begin
            if (m_who == 0) req0 = 1'b0;
            else            req1 = 1'b0;
         end
`endif
         tick();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
